// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register map, APB sequencer
// state encoding and wait counter width.
package timer_pkg;

    localparam logic [11:0] TCR          = 12'h000;
    localparam logic [11:0] TDR0         = 12'h004;
    localparam logic [11:0] TDR1         = 12'h008;
    localparam logic [11:0] TCMP0        = 12'h00C;
    localparam logic [11:0] TCMP1        = 12'h010;
    localparam logic [11:0] TIER         = 12'h014;
    localparam logic [11:0] TISR         = 12'h018;
    localparam logic [11:0] THCSR        = 12'h01C;
    localparam logic [11:0] TIM_ADDR_MAX = THCSR;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

endpackage

// File: rtl/timer_apb_ctrl.sv
// APB4 slave transfer sequencer: latches the setup phase, inserts WAIT_STATES
// access cycles, then issues a single wr_en/rd_en strobe in the completion cycle.
module timer_apb_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned  WAIT_STATES = 0,
    parameter logic [11:0]  ADDR_MAX    = TIM_ADDR_MAX
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tim_psel,
    input  logic        tim_penable,
    input  logic        tim_pwrite,
    input  logic [11:0] tim_paddr,
    input  logic [31:0] tim_pwdata,
    input  logic [3:0]  tim_pstrb,
    output logic        tim_pready,
    output logic [31:0] tim_prdata,
    output logic        tim_pslverr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [11:0] reg_paddr,
    output logic [31:0] reg_pwdata,
    output logic [3:0]  reg_pstrb,
    input  logic [31:0] reg_prdata,
    input  logic        reg_error_flag
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    apb_state_t            state, state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic                  pwrite_q;
    logic                  setup;
    logic                  done;
    logic                  addr_err;

    assign setup    = (state == ST_IDLE) && tim_psel && !tim_penable;
    assign addr_err = (reg_paddr[1:0] != 2'b00) || (reg_paddr > ADDR_MAX);

    // NOTE: the address/data latches are reset too, so the register block never
    // sees X on its bus; that is cheap here because they are plain flops, not RAM.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            pwrite_q   <= 1'b0;
            reg_paddr  <= '0;
            reg_pwdata <= '0;
            reg_pstrb  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (setup) begin
                pwrite_q   <= tim_pwrite;
                reg_paddr  <= tim_paddr;
                reg_pwdata <= tim_pwdata;
                reg_pstrb  <= tim_pstrb;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        done         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (setup) begin
                    state_nxt    = ST_ACCESS;
                    wait_cnt_nxt = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                if (!tim_psel) begin
                    state_nxt = ST_IDLE;
                end else if (tim_penable) begin
                    if (wait_cnt != '0) begin
                        wait_cnt_nxt = wait_cnt - 1'b1;
                    end else begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Everything below is gated by done, so aborted or idle cycles drive zeros.
    assign tim_pready  = done;
    assign wr_en       = done && pwrite_q && !addr_err;
    assign rd_en       = done && !pwrite_q && !addr_err;
    assign tim_pslverr = done && (addr_err || (pwrite_q && reg_error_flag));
    assign tim_prdata  = rd_en ? reg_prdata : 32'h0;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Scoreboard bench: two sequencers (0 and 3 wait states), each with a small
// register-block model; stimulus pushes expectations, a monitor pops on pready.
module tb_timer_apb_ctrl;
    import timer_pkg::*;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        bit          err;
        bit          strobe;
        int          waits;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];
    logic        wr_en   [2];
    logic        rd_en   [2];
    logic [11:0] r_paddr [2];
    logic [31:0] r_pwdata[2];
    logic [3:0]  r_pstrb [2];
    logic [31:0] r_prdata[2];
    logic        r_err   [2];

    logic [31:0] tcr   [2];
    logic [31:0] tcmp0 [2];
    logic [31:0] tcmp1 [2];

    exp_t q0[$];
    exp_t q1[$];
    int   acc_cnt [2];
    int   wr_cnt  [2];
    int   rd_cnt  [2];
    int   checks = 0;
    int   errors = 0;

    always #5 sys_clk = ~sys_clk;

    timer_apb_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tim_psel(psel[0]), .tim_penable(penable[0]), .tim_pwrite(pwrite[0]),
        .tim_paddr(paddr[0]), .tim_pwdata(pwdata[0]), .tim_pstrb(pstrb[0]),
        .tim_pready(pready[0]), .tim_prdata(prdata[0]), .tim_pslverr(pslverr[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .reg_paddr(r_paddr[0]), .reg_pwdata(r_pwdata[0]), .reg_pstrb(r_pstrb[0]),
        .reg_prdata(r_prdata[0]), .reg_error_flag(r_err[0])
    );

    timer_apb_ctrl #(.WAIT_STATES(3)) u_dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tim_psel(psel[1]), .tim_penable(penable[1]), .tim_pwrite(pwrite[1]),
        .tim_paddr(paddr[1]), .tim_pwdata(pwdata[1]), .tim_pstrb(pstrb[1]),
        .tim_pready(pready[1]), .tim_prdata(prdata[1]), .tim_pslverr(pslverr[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .reg_paddr(r_paddr[1]), .reg_pwdata(r_pwdata[1]), .reg_pstrb(r_pstrb[1]),
        .reg_prdata(r_prdata[1]), .reg_error_flag(r_err[1])
    );

    // Register block model: TCR rejects byte-1 writes while the timer is enabled.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            r_err[k]    = wr_en[k] && (r_paddr[k] == TCR) && tcr[k][0] && r_pstrb[k][1];
            r_prdata[k] = 32'h0;
            case (r_paddr[k])
                TCR:     r_prdata[k] = tcr[k];
                TCMP0:   r_prdata[k] = tcmp0[k];
                TCMP1:   r_prdata[k] = tcmp1[k];
                default: r_prdata[k] = 32'h0;
            endcase
        end
    end

    always @(posedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k] && !r_err[k]) begin
                case (r_paddr[k])
                    TCR:     tcr[k]   <= merge(tcr[k],   r_pwdata[k], r_pstrb[k]);
                    TCMP0:   tcmp0[k] <= merge(tcmp0[k], r_pwdata[k], r_pstrb[k]);
                    TCMP1:   tcmp1[k] <= merge(tcmp1[k], r_pwdata[k], r_pstrb[k]);
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic monitor_one(input int k);
        exp_t e;
        if (sys_rst) begin
            acc_cnt[k] = 0;
        end else if (pready[k]) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                check($sformatf("unexpected_pready%0d", k), 32'd1, 32'd0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("pslverr%0d", k), 32'(pslverr[k]), 32'(e.err));
                check($sformatf("wait_cycles%0d", k), acc_cnt[k], e.waits);
                check($sformatf("wr_en%0d", k), 32'(wr_en[k]), 32'(e.wr & e.strobe));
                check($sformatf("rd_en%0d", k), 32'(rd_en[k]), 32'(!e.wr & e.strobe));
                if (!e.wr) check($sformatf("prdata%0d", k), prdata[k], e.rdata);
            end
            wr_cnt[k] += int'(wr_en[k]);
            rd_cnt[k] += int'(rd_en[k]);
            acc_cnt[k] = 0;
        end else begin
            if (wr_en[k] || rd_en[k] || pslverr[k] || prdata[k] != 32'h0)
                check($sformatf("idle_outputs%0d", k),
                      {wr_en[k], rd_en[k], pslverr[k], prdata[k][28:0]}, 32'h0);
            if (psel[k] && penable[k]) acc_cnt[k]++;
            else                       acc_cnt[k] = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            monitor_one(0);
            monitor_one(1);
        end
    end

    task automatic bus_idle(input int k);
        psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
        paddr[k] = '0;  pwdata[k] = '0;    pstrb[k] = '0;
    endtask

    task automatic xfer(input int k, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_err,
                        input bit exp_strobe);
        exp_t e;
        int   n;
        e.wr = wr; e.rdata = exp_rd; e.err = exp_err; e.strobe = exp_strobe;
        e.waits = (k == 0) ? 0 : 3;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge sys_clk); #1;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = a;   pwdata[k] = d;     pstrb[k] = s;
        @(posedge sys_clk); #1;
        penable[k] = 1'b1;
        paddr[k] = ~a; pwdata[k] = ~d; pstrb[k] = ~s;
        n = 0;
        while (n < 40) begin
            @(negedge sys_clk);
            if (pready[k]) break;
            n++;
        end
        if (n == 40) check($sformatf("pready_timeout%0d", k), 32'd0, 32'd1);
        @(posedge sys_clk); #1;
        bus_idle(k);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            bus_idle(k);
            tcr[k] = 32'h0; tcmp0[k] = 32'hFFFF_FFFF; tcmp1[k] = 32'hFFFF_FFFF;
            acc_cnt[k] = 0; wr_cnt[k] = 0; rd_cnt[k] = 0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            check("rst_outputs", {pready[k], pslverr[k], wr_en[k], rd_en[k]}, 32'h0);
            check("rst_prdata", prdata[k], 32'h0);
            check("rst_reg_bus", {r_paddr[k], r_pstrb[k]} | r_pwdata[k], 32'h0);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Zero-wait write, readback; 3-wait read of TCMP0 reset value.
        xfer(0, 1'b1, TCR,   32'h0000_0103, 4'h3, 32'h0, 1'b0, 1'b1);
        xfer(0, 1'b0, TCR,   32'h0,         4'h0, 32'h0000_0103, 1'b0, 1'b1);
        xfer(1, 1'b0, TCMP0, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("tcr_after_write", tcr[0], 32'h0000_0103);

        // Enabled timer rejects a div write; TCR must keep its value.
        xfer(0, 1'b1, TCR,   32'h0000_0000, 4'h2, 32'h0, 1'b1, 1'b1);
        xfer(0, 1'b0, TCR,   32'h0,         4'h0, 32'h0000_0103, 1'b0, 1'b1);

        // Decode faults and the highest legal address.
        xfer(0, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 1'b0);
        xfer(0, 1'b0, 12'h006, 32'h0,         4'h0, 32'h0, 1'b1, 1'b0);
        xfer(0, 1'b0, THCSR,   32'h0,         4'h0, 32'h0, 1'b0, 1'b1);
        xfer(1, 1'b0, THCSR,   32'h0,         4'h0, 32'h0, 1'b0, 1'b1);
        xfer(1, 1'b1, 12'h01D, 32'h1,         4'hF, 32'h0, 1'b1, 1'b0);

        // Abort after one access cycle, then penable-only cycles must be ignored.
        @(posedge sys_clk); #1;
        psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = TCMP1; pwdata[1] = 32'h1111_1111; pstrb[1] = 4'hF;
        @(posedge sys_clk); #1;
        penable[1] = 1'b1;
        @(posedge sys_clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge sys_clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        bus_idle(1);
        check("abort_no_write", tcmp1[1], 32'hFFFF_FFFF);
        xfer(1, 1'b1, TCMP1, 32'hA5A5_0000, 4'hF, 32'h0, 1'b0, 1'b1);
        xfer(1, 1'b0, TCMP1, 32'h0,         4'h0, 32'hA5A5_0000, 1'b0, 1'b1);

        // Reset during an access wait.
        @(posedge sys_clk); #1;
        psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = TCMP0; pwdata[1] = 32'h1234_5678; pstrb[1] = 4'hF;
        @(posedge sys_clk); #1;
        penable[1] = 1'b1;
        @(posedge sys_clk); #3;
        sys_rst = 1'b1;
        #1;
        check("rst_mid_outputs", {pready[1], pslverr[1], wr_en[1], rd_en[1]}, 32'h0);
        check("rst_mid_prdata", prdata[1], 32'h0);
        check("rst_mid_paddr", 32'(r_paddr[1]), 32'h0);
        check("rst_mid_pwdata", r_pwdata[1], 32'h0);
        check("rst_mid_pstrb", 32'(r_pstrb[1]), 32'h0);
        bus_idle(1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("tcmp0_kept", tcmp0[1], 32'hFFFF_FFFF);
        xfer(1, 1'b0, TCMP0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);

        repeat (2) @(posedge sys_clk);
        #1;
        check("wr_count0", wr_cnt[0], 2);
        check("rd_count0", rd_cnt[0], 3);
        check("wr_count1", wr_cnt[1], 1);
        check("rd_count1", rd_cnt[1], 4);
        check("queue0_empty", q0.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
